// File: rtl/core_rrv_rf_wb_sched_if.sv
// Handshake and data bundle between the Q105H write-back stage, the
// long-latency unit, the Q101H decode stage and the register file write port.
interface core_rrv_rf_wb_sched_if;
   // Pipeline write-back (Q105H)
   logic        PipeWrEnQ105H;
   logic [4:0]  PipeRegDstQ105H;
   logic [31:0] PipeWrDataQ105H;
   // Decode-stage operands (Q101H)
   logic [4:0]  RegSrc1Q101H;
   logic [4:0]  RegSrc2Q101H;
   logic [4:0]  RegDstQ101H;
   logic        RegWrEnQ101H;
   // Long op issue (Q102H)
   logic        LongIssueValid;
   logic [4:0]  LongIssueRd;
   logic        LongIssueReady;
   // Long op result
   logic        LongRspValid;
   logic [4:0]  LongRspRd;
   logic [31:0] LongRspData;
   logic        LongRspReady;
   // Decode hold
   logic        StallQ101H;
   // Register file write port
   logic        RfWrEnQ105H;
   logic [4:0]  RfRegDstQ105H;
   logic [31:0] RfWrDataQ105H;

   // Driver side: the pipeline, long unit and register file around the scheduler
   modport master (
      output PipeWrEnQ105H, PipeRegDstQ105H, PipeWrDataQ105H,
      output RegSrc1Q101H, RegSrc2Q101H, RegDstQ101H, RegWrEnQ101H,
      output LongIssueValid, LongIssueRd,
      input  LongIssueReady,
      output LongRspValid, LongRspRd, LongRspData,
      input  LongRspReady,
      input  StallQ101H,
      input  RfWrEnQ105H, RfRegDstQ105H, RfWrDataQ105H
   );

   // Scheduler side
   modport slave (
      input  PipeWrEnQ105H, PipeRegDstQ105H, PipeWrDataQ105H,
      input  RegSrc1Q101H, RegSrc2Q101H, RegDstQ101H, RegWrEnQ101H,
      input  LongIssueValid, LongIssueRd,
      output LongIssueReady,
      input  LongRspValid, LongRspRd, LongRspData,
      output LongRspReady,
      output StallQ101H,
      output RfWrEnQ105H, RfRegDstQ105H, RfWrDataQ105H
   );
endinterface

// File: rtl/core_rrv_rf_wb_sched.sv
// Write-back scheduler: shares the single Q105H register file write port
// between the in-order pipeline and one out-of-band long-latency unit, keeps
// a scoreboard of destinations owned by in-flight long ops and stalls Q101H
// on RAW/WAW hazards or when a held long result has starved too long.
module core_rrv_rf_wb_sched #(
   parameter int RF_NUM_MSB   = 31,
   parameter int STARVE_LIMIT = 8
) (
   input logic                    Clock,
   input logic                    Rst,
   core_rrv_rf_wb_sched_if.slave  bus
);

   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   // Scoreboard, stored 32 wide for simple indexing; x0 and bits above
   // RF_NUM_MSB are kept at zero.
   logic [31:0] pending_q, pending_d;
   logic        bufValid_q, bufValid_d;
   logic [4:0]  bufRd_q, bufRd_d;
   logic [31:0] bufData_q, bufData_d;
   logic [7:0]  starveCnt_q, starveCnt_d;

   logic        pipeFree;
   logic        bufDrain;
   logic        rspAccept;
   logic        issueReady;
   logic        issueAccept;
   logic        starveStall;
   logic        rawHaz;
   logic        wawHaz;
   logic [31:0] effPending;

   // Port arbitration, handshakes and hazard detection. The pipeline always
   // wins the port; the buffer drains only into a free (idle or x0) slot, and
   // a draining destination is treated as already written because the RF
   // forwards the Q105H write to the Q101H read.
   always_comb begin
      pipeFree    = !bus.PipeWrEnQ105H || (bus.PipeRegDstQ105H == 5'd0);
      bufDrain    = !Rst && pipeFree && bufValid_q;

      bus.RfWrEnQ105H   = bus.PipeWrEnQ105H;
      bus.RfRegDstQ105H = bus.PipeRegDstQ105H;
      bus.RfWrDataQ105H = bus.PipeWrDataQ105H;
      if (bufDrain) begin
         bus.RfWrEnQ105H   = 1'b1;
         bus.RfRegDstQ105H = bufRd_q;
         bus.RfWrDataQ105H = bufData_q;
      end

      bus.LongRspReady = !bufValid_q && !Rst;
      rspAccept        = bus.LongRspValid && bus.LongRspReady;

      issueReady = !Rst && ((bus.LongIssueRd == 5'd0) || !pending_q[bus.LongIssueRd]);
      bus.LongIssueReady = issueReady;
      issueAccept = bus.LongIssueValid && issueReady;

      effPending = pending_q;
      if (bufDrain) begin
         effPending[bufRd_q] = 1'b0;
      end

      rawHaz = ((bus.RegSrc1Q101H != 5'd0) && effPending[bus.RegSrc1Q101H]) ||
               ((bus.RegSrc2Q101H != 5'd0) && effPending[bus.RegSrc2Q101H]);
      wawHaz = bus.RegWrEnQ101H && (bus.RegDstQ101H != 5'd0) &&
               effPending[bus.RegDstQ101H];
      starveStall = (starveCnt_q == STARVE_MAX);
      bus.StallQ101H = !Rst && (rawHaz || wawHaz || starveStall);
   end

   // Next-state for scoreboard, hold buffer and starvation counter. An issue
   // and a drain never hit the same register in one cycle because issue
   // readiness requires the pending bit to be clear.
   always_comb begin
      pending_d = pending_q;
      if (issueAccept && (bus.LongIssueRd != 5'd0)) begin
         pending_d[bus.LongIssueRd] = 1'b1;
      end
      if (bufDrain) begin
         pending_d[bufRd_q] = 1'b0;
      end
      for (int i = 0; i < 32; i++) begin
         if ((i == 0) || (i > RF_NUM_MSB)) begin
            pending_d[i] = 1'b0;
         end
      end

      bufValid_d = bufValid_q;
      bufRd_d    = bufRd_q;
      bufData_d  = bufData_q;
      if (bufDrain) begin
         bufValid_d = 1'b0;
      end
      if (rspAccept) begin
         bufValid_d = 1'b1;
         bufRd_d    = bus.LongRspRd;
         bufData_d  = bus.LongRspData;
      end

      starveCnt_d = 8'd0;
      if (bufValid_q && !bufDrain) begin
         starveCnt_d = (starveCnt_q == STARVE_MAX) ? starveCnt_q : starveCnt_q + 8'd1;
      end
   end

   // State registers; reset discards any held result and the whole scoreboard.
   always_ff @(posedge Clock) begin
      if (Rst) begin
         pending_q   <= '0;
         bufValid_q  <= 1'b0;
         bufRd_q     <= 5'd0;
         bufData_q   <= 32'd0;
         starveCnt_q <= 8'd0;
      end else begin
         pending_q   <= pending_d;
         bufValid_q  <= bufValid_d;
         bufRd_q     <= bufRd_d;
         bufData_q   <= bufData_d;
         starveCnt_q <= starveCnt_d;
      end
   end

endmodule

// File: tb/tb_core_rrv_rf_wb_sched.sv
// Testbench for core_rrv_rf_wb_sched: directed stimulus with a reference
// model of the hold buffer, scoreboard and starvation counter; expected RF
// writes are queued when driven/accepted and compared when they appear.
module tb_core_rrv_rf_wb_sched;

   localparam int LIMIT = 8;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wbEntry_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checkCount = 0;
   int   passCount  = 0;

   wbEntry_t    pipeQ[$];
   wbEntry_t    longQ[$];
   logic [31:0] mPend = '0;
   int          mCnt  = 0;

   core_rrv_rf_wb_sched_if bus ();

   core_rrv_rf_wb_sched #(.RF_NUM_MSB(31), .STARVE_LIMIT(LIMIT)) dut (
      .Clock (clk),
      .Rst   (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Single comparison point; counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic setPipe(input logic en, input logic [4:0] dst, input logic [31:0] data);
      bus.PipeWrEnQ105H   = en;
      bus.PipeRegDstQ105H = dst;
      bus.PipeWrDataQ105H = data;
   endtask

   task automatic setDecode(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d, input logic wen);
      bus.RegSrc1Q101H = s1;
      bus.RegSrc2Q101H = s2;
      bus.RegDstQ101H  = d;
      bus.RegWrEnQ101H = wen;
   endtask

   task automatic setIssue(input logic [4:0] rd);
      bus.LongIssueValid = 1'b1;
      bus.LongIssueRd    = rd;
   endtask

   task automatic setRsp(input logic [4:0] rd, input logic [31:0] data);
      bus.LongRspValid = 1'b1;
      bus.LongRspRd    = rd;
      bus.LongRspData  = data;
   endtask

   // Hold current inputs for n cycles; issue/response are one-cycle pulses,
   // pipe writes are queued as expected RF writes for every cycle they last.
   task automatic applyStimulus(input int n);
      for (int c = 0; c < n; c++) begin
         if (bus.PipeWrEnQ105H && bus.PipeRegDstQ105H != 5'd0)
            pipeQ.push_back('{rd: bus.PipeRegDstQ105H, data: bus.PipeWrDataQ105H});
         @(posedge clk);
         #1;
         bus.LongIssueValid = 1'b0;
         bus.LongRspValid   = 1'b0;
      end
   endtask

   // Reference model evaluated mid-cycle: checks all outputs, then advances.
   always @(negedge clk) begin
      logic        pipeBusy, bufV, drainM, acceptM, issReadyM, stallM;
      logic [31:0] effPend;
      wbEntry_t    e;
      pipeBusy  = bus.PipeWrEnQ105H && (bus.PipeRegDstQ105H != 5'd0);
      bufV      = (longQ.size() != 0);
      drainM    = !rst && !pipeBusy && bufV;
      acceptM   = !rst && !bufV && bus.LongRspValid;
      issReadyM = !rst && ((bus.LongIssueRd == 5'd0) || !mPend[bus.LongIssueRd]);

      checkOutput("rspReady", {31'd0, bus.LongRspReady}, {31'd0, !rst && !bufV});
      checkOutput("issReady", {31'd0, bus.LongIssueReady}, {31'd0, issReadyM});

      effPend = mPend;
      if (drainM) effPend[longQ[0].rd] = 1'b0;
      stallM = !rst && (((bus.RegSrc1Q101H != 5'd0) && effPend[bus.RegSrc1Q101H]) ||
                        ((bus.RegSrc2Q101H != 5'd0) && effPend[bus.RegSrc2Q101H]) ||
                        (bus.RegWrEnQ101H && (bus.RegDstQ101H != 5'd0) && effPend[bus.RegDstQ101H]) ||
                        (mCnt == LIMIT));
      checkOutput("stall", {31'd0, bus.StallQ101H}, {31'd0, stallM});

      if (pipeBusy) begin
         if (pipeQ.size() == 0) checkOutput("pipeQ underflow", 32'd0, 32'd1);
         else begin
            e = pipeQ.pop_front();
            checkOutput("pipe wrEn", {31'd0, bus.RfWrEnQ105H}, 32'd1);
            checkOutput("pipe dst", {27'd0, bus.RfRegDstQ105H}, {27'd0, e.rd});
            checkOutput("pipe data", bus.RfWrDataQ105H, e.data);
         end
      end else if (drainM) begin
         e = longQ[0];
         checkOutput("drain wrEn", {31'd0, bus.RfWrEnQ105H}, 32'd1);
         checkOutput("drain dst", {27'd0, bus.RfRegDstQ105H}, {27'd0, e.rd});
         checkOutput("drain data", bus.RfWrDataQ105H, e.data);
      end else begin
         checkOutput("idle wrEn", {31'd0, bus.RfWrEnQ105H}, {31'd0, bus.PipeWrEnQ105H});
      end

      if (rst) begin
         mPend = '0;
         mCnt  = 0;
         longQ.delete();
      end else begin
         if (bus.LongIssueValid && issReadyM && bus.LongIssueRd != 5'd0)
            mPend[bus.LongIssueRd] = 1'b1;
         mCnt = (bufV && !drainM) ? ((mCnt == LIMIT) ? mCnt : mCnt + 1) : 0;
         if (drainM) begin
            e = longQ.pop_front();
            if (e.rd != 5'd0) mPend[e.rd] = 1'b0;
         end
         if (acceptM) longQ.push_back('{rd: bus.LongRspRd, data: bus.LongRspData});
      end
   end

   initial begin
      setPipe(1'b0, 5'd0, 32'd0);
      setDecode(5'd0, 5'd0, 5'd0, 1'b0);
      bus.LongIssueValid = 1'b0;
      bus.LongIssueRd    = 5'd0;
      bus.LongRspValid   = 1'b0;
      bus.LongRspRd      = 5'd0;
      bus.LongRspData    = 32'd0;
      rst = 1'b1;
      applyStimulus(2);
      rst = 1'b0;

      $display("[TB] basic long result to rd=5");
      setIssue(5'd5);
      applyStimulus(3);
      setRsp(5'd5, 32'hDEADBEEF);
      applyStimulus(3);

      $display("[TB] RAW hazard on rd=7");
      setIssue(5'd7);
      applyStimulus(1);
      setDecode(5'd7, 5'd0, 5'd0, 1'b0);
      applyStimulus(3);
      setRsp(5'd7, 32'h0000_7777);
      applyStimulus(3);

      $display("[TB] WAW hazard on rd=7");
      setDecode(5'd0, 5'd0, 5'd7, 1'b1);
      setIssue(5'd7);
      applyStimulus(3);
      setRsp(5'd7, 32'h7777_0000);
      applyStimulus(3);
      setDecode(5'd0, 5'd0, 5'd0, 1'b0);

      $display("[TB] starvation with pipe writing rd=3");
      setIssue(5'd10);
      setDecode(5'd10, 5'd0, 5'd0, 1'b0);
      applyStimulus(1);
      for (int i = 0; i < 14; i++) begin
         setPipe(1'b1, 5'd3, 32'h3000 + i);
         if (i == 1) setRsp(5'd10, 32'hA5A5_5A5A);
         applyStimulus(1);
      end
      setPipe(1'b1, 5'd0, 32'h0BAD_0000);
      applyStimulus(1);
      setPipe(1'b0, 5'd0, 32'd0);
      setDecode(5'd0, 5'd0, 5'd0, 1'b0);
      applyStimulus(2);

      $display("[TB] issue readiness against scoreboard");
      setIssue(5'd9);
      applyStimulus(1);
      setIssue(5'd9);
      applyStimulus(1);
      setIssue(5'd0);
      applyStimulus(1);
      setRsp(5'd9, 32'h9999_9999);
      applyStimulus(3);

      $display("[TB] long result to x0");
      setDecode(5'd1, 5'd2, 5'd3, 1'b1);
      setRsp(5'd0, 32'h1234_5678);
      applyStimulus(3);
      setDecode(5'd0, 5'd0, 5'd0, 1'b0);

      $display("[TB] reset with full buffer");
      setIssue(5'd4);
      applyStimulus(1);
      setIssue(5'd11);
      applyStimulus(1);
      setPipe(1'b1, 5'd2, 32'h2222_0001);
      setRsp(5'd11, 32'hCAFE_F00D);
      applyStimulus(3);
      setPipe(1'b0, 5'd0, 32'd0);
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      setDecode(5'd4, 5'd11, 5'd4, 1'b1);
      applyStimulus(3);
      setDecode(5'd0, 5'd0, 5'd0, 1'b0);
      applyStimulus(2);

      checkOutput("pipeQ empty", pipeQ.size(), 32'd0);
      checkOutput("longQ empty", longQ.size(), 32'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/core_rrv_rf_wb_sched.md
# core_rrv_rf_wb_sched

Write-back scheduler for the core_rrv register file's single Q105H write port. It shares that port between the in-order pipeline write-back and one multi-cycle execution unit (divider / long-latency load) that returns results out of band. It keeps a scoreboard of destinations owned by in-flight long ops and stalls Q101H on RAW/WAW hazards against them. It sits between the Q105H write-back stage, the long unit and the register file write inputs.

## Interface
Parameters:
- RF_NUM_MSB, 31, highest implemented register index; scoreboard covers 1..RF_NUM_MSB, x0 never tracked
- STARVE_LIMIT, 8, cycles a held long result may wait before forced bubbles are requested (>=1, <=255)

Ports:
- Clock  in  1  core clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- PipeWrEnQ105H  in  1  pipeline write-back valid
- PipeRegDstQ105H  in  5  pipeline destination
- PipeWrDataQ105H  in  32  pipeline write data
- RegSrc1Q101H / RegSrc2Q101H  in  5 each  decode-stage sources
- RegDstQ101H  in  5  decode-stage destination
- RegWrEnQ101H  in  1  decode-stage instruction writes RegDstQ101H
- LongIssueValid  in  1  long op issued this cycle (Q102H)
- LongIssueRd  in  5  long op destination
- LongIssueReady  out  1  issue accepted this cycle
- LongRspValid  in  1  long unit result valid
- LongRspRd  in  5  result destination
- LongRspData  in  32  result data
- LongRspReady  out  1  result accepted this cycle
- StallQ101H  out  1  hold Q101H (hazard or forced bubble)
- RfWrEnQ105H  out  1  register file write enable
- RfRegDstQ105H  out  5  register file write address
- RfWrDataQ105H  out  32  register file write data

## Operation
- State: Pending[RF_NUM_MSB:1], one-entry hold buffer (BufValid, BufRd, BufData), 8-bit StarveCnt.
- Port arbitration, combinational: PipeFree = !PipeWrEnQ105H || PipeRegDstQ105H==0. If !PipeFree -> pipe drives Rf* outputs. Else if BufValid -> buffer drives Rf* (BufDrain=1). Else Rf* = pipe inputs. Pipeline always has priority; it can never stall.
- LongRspReady = !BufValid && !Rst (state-only, no path from LongRspValid). Accept = LongRspValid && LongRspReady -> BufValid<=1, capture Rd/Data.
- BufDrain -> BufValid<=0, Pending[BufRd]<=0. Drain and accept never coincide (accept requires empty buffer).
- Result with LongRspRd==0: accepted, drained with RfWrEn=1 to x0 (RF ignores), no Pending change.
- LongIssueReady = !Rst && (LongIssueRd==0 || !Pending[LongIssueRd]). Issue accepted -> Pending[LongIssueRd]<=1 (not for x0). Issue and drain to same rd in one cycle: ready is 0 (Pending still set); no conflict.
- Hazard: EffPending = Pending with bit BufRd cleared when BufDrain (RF forwards Q105H write to Q101H read). StallQ101H = RAW (nonzero src with EffPending set) || WAW (RegWrEnQ101H, nonzero dst, EffPending set) || StarveStall.
- Starvation: StarveCnt increments each cycle BufValid && !BufDrain, saturates at STARVE_LIMIT, clears on drain or !BufValid. StarveStall = StarveCnt==STARVE_LIMIT; held until drain; injected bubbles reach Q105H and free the port.
- Reset mid-operation: held result discarded, Pending cleared, counter cleared; long unit must be flushed by the same reset.

## Timing
- Reset values: BufValid=0, Pending=0, StarveCnt=0; LongRspReady=0, LongIssueReady=0, StallQ101H=0 during Rst; Rf* outputs follow pipe inputs.
- Result accepted cycle T -> earliest RF write T+1 (pipe free), later if pipe busy.
- Pending set at edge after issue; visible to StallQ101H in cycle issue+1.
- Dependent read in Q101H unstalls in the drain cycle itself (forwarded by RF).
- Throughput: one long result per 2 cycles max (accept, drain).
- Forced bubble: StallQ101H rises STARVE_LIMIT cycles after buffer fill with no free slot.

## Test plan
- Issue rd=5, result 0xDEADBEEF 3 cycles later, pipe idle -> RfWrEn=1, dst=5, data=0xDEADBEEF one cycle after accept; Pending[5] clears; LongRspReady low exactly one cycle.
- Pending[7], Q101H src1=7 -> StallQ101H=1 until drain cycle, 0 in drain cycle; WAW (dst=7, RegWrEn=1) stalls identically.
- Buffer held, pipe writes rd=3 every cycle, STARVE_LIMIT=8 -> pipe data wins every cycle, StallQ101H=1 from 8th wait cycle; first pipe write to x0/idle drains buffer, stall drops.
- Issue rd=9 while Pending[9]=1 -> LongIssueReady=0; issue rd=0 -> ready=1, Pending unchanged.
- Long result rd=0 -> accepted, RF write to x0, no scoreboard change, no stalls.
- Rst asserted with buffer full and Pending[4] set -> next cycle BufValid=0, Pending=0, StallQ101H=0, no RF write of held data.
